// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and sequencer state encoding.
// Used by the serial adder, the combinational subtractor and the ALU sequencer.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/fa_inc_cell.sv
// Single-bit carry full adder; carry-polarity mirror of the borrow full-subtractor cell.
module fa_inc_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic z,
    output logic cout
);

    assign z    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/rca_serial_add.sv
// Bit-serial adder: one full-adder cell and a carry flop iterated LSB-first over WIDTH cycles,
// with a start/busy/done handshake; sum, cout and ovf are registered and update only on completion.
module rca_serial_add
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             msb_carry_q, msb_carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic cell_z;
    logic cell_cout;

    fa_inc_cell u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .cin  (carry_q),
        .z    (cell_z),
        .cout (cell_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        msb_carry_d = msb_carry_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                // Result fills from the MSB side so bit 0 lands at the LSB after WIDTH shifts.
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {cell_z, res_sh_q[WIDTH-1:1]};
                carry_d  = cell_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 2)) begin
                    msb_carry_d = cell_cout;
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = res_sh_d;
                    cout_d  = cell_cout;
                    ovf_d   = msb_carry_q ^ cell_cout;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            msb_carry_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            msb_carry_q <= msb_carry_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca_serial_add.sv
// Self-checking bench for rca_serial_add: directed vector table, hand-written multi-cycle
// sequences and randomized operations checked against an arithmetic reference model.
module tb_rca_serial_add;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;

    typedef struct {
        string        name;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
        int           inj;
    } vec_t;

    rca_serial_add #(.WIDTH(W), .CNT_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition; overflow when like-signed operands give an unlike-signed sum.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        logic [W:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {v, t};
    endfunction

    // Runs one operation from IDLE; inj >= 0 pulses a stray start with junk operands mid-run.
    task automatic do_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vcin, input logic [W-1:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf, input int inj);
        bit ok;
        a     = va;
        b     = vb;
        cin   = vcin;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        ok    = 1'b1;
        for (int i = 0; i < int'(W); i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || sum !== held_sum ||
                cout !== held_cout || ovf !== held_ovf) ok = 1'b0;
            if (i == inj) begin
                start = 1'b1;
                a     = 16'hAAAA;
                b     = 16'h5555;
                cin   = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk({name, " run_window"}, 32'(ok), 32'd1);
        chk({name, " busy_done"}, {busy, done}, 2'b01);
        chk({name, " sum"}, sum, exp_sum);
        chk({name, " cout"}, cout, exp_cout);
        chk({name, " ovf"}, ovf, exp_ovf);
        held_sum  = exp_sum;
        held_cout = exp_cout;
        held_ovf  = exp_ovf;
        tick();
        chk({name, " post_idle"}, {busy, done}, 2'b00);
    endtask

    initial begin
        vec_t         vecs[6];
        logic [W+1:0] r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           n;
        int           dones;

        vecs[0] = '{"basic",    16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0, -1};
        vecs[1] = '{"wrap",     16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, -1};
        vecs[2] = '{"pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, -1};
        vecs[3] = '{"ignored",  16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0,  4};
        vecs[4] = '{"neg_ovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, -1};
        vecs[5] = '{"all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, -1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset sum",  sum,  16'h0000);
        chk("reset cout", cout, 1'b0);
        chk("reset ovf",  ovf,  1'b0);
        held_sum  = '0;
        held_cout = 1'b0;
        held_ovf  = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vcin,
                  vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, vecs[i].inj);
        end

        // Back-to-back: start held high through the DONE cycle.
        a     = 16'h8000;
        b     = 16'h8000;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("b2b first_latency", n, 16);
        chk("b2b first_sum", {ovf, cout, sum}, {1'b1, 1'b1, 16'h0000});
        tick();
        start = 1'b0;
        a     = 16'h0001;
        b     = 16'h0001;
        chk("b2b no_gap", {busy, done}, 2'b10);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("b2b period", n, 17);
        chk("b2b second_sum", {ovf, cout, sum}, {1'b1, 1'b1, 16'h0000});
        held_sum  = 16'h0000;
        held_cout = 1'b1;
        held_ovf  = 1'b1;
        tick();
        chk("b2b post_idle", {busy, done}, 2'b00);

        // Mid-operation reset after a non-zero result is on the outputs.
        do_op("pre_reset", 16'h00F0, 16'h0F0F, 1'b1, 16'h1000, 1'b0, 1'b0, -1);
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst outputs", {busy, done, cout, ovf, sum}, 20'h0);
        held_sum  = '0;
        held_cout = 1'b0;
        held_ovf  = 1'b0;
        dones = 0;
        for (int i = 0; i < 24; i++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            tick();
        end
        chk("midrst no_done", dones, 0);
        do_op("after_reset", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (k % 8 == 0) rb = ~ra;
            r = ref_add(ra, rb, rc);
            do_op($sformatf("rand%0d", k), ra, rb, rc, r[W-1:0], r[W], r[W+1], -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
